// File: rtl/seven_seg_display_driver.sv
// 8-digit multiplexed common-anode hex display for the processor's V0/V1 debug words.
// V0/V1/Sel are snapshotted once per scan frame so a frame never shows a torn value.
module seven_seg_display_driver #(
  parameter int unsigned CLK_DIV  = 100000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] V0,
  input  logic [31:0] V1,
  input  logic [1:0]  Sel,
  input  logic        Freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        FrameDone
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_V0     = 2'b00,
    MODE_V1     = 2'b01,
    MODE_SPLIT  = 2'b10,
    MODE_V0_ALT = 2'b11
  } mode_e;

  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic [63:0]   snap_q;
  mode_e         mode_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick, load;
  logic [31:0]   w;
  logic [3:0]    cur_nib;
  logic [7:0]    blank;
  logic          run;
  logic [2:0]    d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick      = (presc_q == PW'(CLK_DIV - 1));
  assign load      = tick && (idx_q == 3'd7) && !Freeze;
  assign FrameDone = load && !Reset;

  always_comb begin
    case (mode_q)
      MODE_V1:    w = snap_q[63:32];
      MODE_SPLIT: w = {snap_q[47:32], snap_q[15:0]};
      default:    w = snap_q[31:0];
    endcase
  end

  assign cur_nib = w[{idx_q, 2'b00} +: 4];

  // Walk from the top digit down, tracking "all nibbles so far are zero";
  // split mode restarts the run at digit 3 so each half blanks on its own.
  always_comb begin
    blank = '0;
    run   = 1'b1;
    d     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      d = 3'(7 - k);
      if (mode_q == MODE_SPLIT && d == 3'd3) run = 1'b1;
      run      = run && (w[{d, 2'b00} +: 4] == 4'h0);
      blank[d] = LZ_BLANK && run && (d != 3'd0) && !(mode_q == MODE_SPLIT && d == 3'd4);
    end
  end

  always_comb begin
    an_d  = blank[idx_q] ? '1 : ~(8'b1 << idx_q);
    seg_d = hex7(cur_nib);
    dp_d  = !(mode_q == MODE_SPLIT && idx_q == 3'd4);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      mode_q  <= MODE_V0;
      an_q    <= '1;
      seg_q   <= '1;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) idx_q <= idx_q + 3'd1;
      if (load) begin
        snap_q <= {V1, V0};
        mode_q <= mode_e'(Sel);
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
